// File: rtl/PKG_pwm.sv
// Shared PWM package: core widths and mode types, plus the shadow loader's
// address map, FSM state enum and mode-word field positions.
package PKG_pwm;

    localparam int unsigned PWMCOUNT_WIDTH = 16;
    localparam int unsigned DTCOUNT_WIDTH  = 12;
    localparam int unsigned EVTCOUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        COUNT_UP     = 2'd0,
        COUNT_DOWN   = 2'd1,
        COUNT_UPDOWN = 2'd2
    } _count_mode;

    typedef enum logic [1:0] {
        NO_MASK     = 2'd0,
        MIN_MASK    = 2'd1,
        MAX_MASK    = 2'd2,
        MINMAX_MASK = 2'd3
    } _mask_mode;

    typedef enum logic {
        CARR_OFF = 1'b0,
        CARR_ON  = 1'b1
    } _carr_onoff;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    localparam int unsigned SHD_AW = 3;

    localparam logic [SHD_AW-1:0] SHD_ADDR_PERIOD   = 3'd0;
    localparam logic [SHD_AW-1:0] SHD_ADDR_COMPARE  = 3'd1;
    localparam logic [SHD_AW-1:0] SHD_ADDR_INITCARR = 3'd2;
    localparam logic [SHD_AW-1:0] SHD_ADDR_EVTCNT   = 3'd3;
    localparam logic [SHD_AW-1:0] SHD_ADDR_DTIME_A  = 3'd4;
    localparam logic [SHD_AW-1:0] SHD_ADDR_DTIME_B  = 3'd5;
    localparam logic [SHD_AW-1:0] SHD_ADDR_MODE     = 3'd6;
    localparam logic [SHD_AW-1:0] SHD_ADDR_RSVD     = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOAD  = 2'd2
    } _shadow_state;

    // Mode word (address 6) field positions
    localparam int unsigned MODE_CNT_LSB  = 0;
    localparam int unsigned MODE_MSK_LSB  = 2;
    localparam int unsigned MODE_CARR_BIT = 4;
    localparam int unsigned MODE_SEL_LSB  = 5;
    localparam int unsigned MODE_LA_BIT   = 8;
    localparam int unsigned MODE_LB_BIT   = 9;

endpackage

// File: rtl/pwm_shadow_bank.sv
// Shadow/active register pair for the PWM channel-1 settings; the active bank
// takes the whole shadow bank on load, with compare clamped to period.
module pwm_shadow_bank
    import PKG_pwm::*;
#(
    parameter int unsigned PW = PWMCOUNT_WIDTH,
    parameter int unsigned DW = DTCOUNT_WIDTH,
    parameter int unsigned EW = EVTCOUNT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SHD_AW-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              load,
    output logic [PW-1:0]     period_c1,
    output logic [PW-1:0]     compare_c1,
    output logic [PW-1:0]     initcarr_c1,
    output logic [EW-1:0]     eventcount_c1,
    output logic [DW-1:0]     dtime_A_c1,
    output logic [DW-1:0]     dtime_B_c1,
    output _count_mode        countmode_c1,
    output _mask_mode         maskmode_c1,
    output _carr_onoff        carr_onoff_c1,
    output logic [2:0]        carrsel_c1,
    output logic              logic_A_c1,
    output logic              logic_B_c1
);

    logic [PW-1:0] period_s, compare_s, initcarr_s, compare_load;
    logic [EW-1:0] eventcount_s;
    logic [DW-1:0] dtime_A_s, dtime_B_s;
    _count_mode    countmode_s;
    _mask_mode     maskmode_s;
    _carr_onoff    carr_onoff_s;
    logic [2:0]    carrsel_s;
    logic          logic_A_s, logic_B_s;

    // Shadow bank: software-visible staging registers
    always_ff @(posedge clk) begin
        if (reset) begin
            period_s     <= '0;
            compare_s    <= '0;
            initcarr_s   <= '0;
            eventcount_s <= '0;
            dtime_A_s    <= '0;
            dtime_B_s    <= '0;
            countmode_s  <= COUNT_UPDOWN;
            maskmode_s   <= MIN_MASK;
            carr_onoff_s <= CARR_OFF;
            carrsel_s    <= 3'd0;
            logic_A_s    <= 1'b1;
            logic_B_s    <= 1'b1;
        end else if (wr_en) begin
            case (wr_addr)
                SHD_ADDR_PERIOD:   period_s     <= PW'(wr_data);
                SHD_ADDR_COMPARE:  compare_s    <= PW'(wr_data);
                SHD_ADDR_INITCARR: initcarr_s   <= PW'(wr_data);
                SHD_ADDR_EVTCNT:   eventcount_s <= EW'(wr_data);
                SHD_ADDR_DTIME_A:  dtime_A_s    <= DW'(wr_data);
                SHD_ADDR_DTIME_B:  dtime_B_s    <= DW'(wr_data);
                SHD_ADDR_MODE: begin
                    countmode_s  <= _count_mode'(wr_data[MODE_CNT_LSB +: 2]);
                    maskmode_s   <= _mask_mode'(wr_data[MODE_MSK_LSB +: 2]);
                    carr_onoff_s <= _carr_onoff'(wr_data[MODE_CARR_BIT]);
                    carrsel_s    <= wr_data[MODE_SEL_LSB +: 3];
                    logic_A_s    <= wr_data[MODE_LA_BIT];
                    logic_B_s    <= wr_data[MODE_LB_BIT];
                end
                default: ;
            endcase
        end
    end

    // A compare beyond the period would never match; pin it to the period
    always_comb begin
        compare_load = compare_s;
        if (compare_s > period_s) compare_load = period_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_c1     <= '0;
            compare_c1    <= '0;
            initcarr_c1   <= '0;
            eventcount_c1 <= '0;
            dtime_A_c1    <= '0;
            dtime_B_c1    <= '0;
            countmode_c1  <= COUNT_UPDOWN;
            maskmode_c1   <= MIN_MASK;
            carr_onoff_c1 <= CARR_OFF;
            carrsel_c1    <= 3'd0;
            logic_A_c1    <= 1'b1;
            logic_B_c1    <= 1'b1;
        end else if (load) begin
            period_c1     <= period_s;
            compare_c1    <= compare_load;
            initcarr_c1   <= initcarr_s;
            eventcount_c1 <= eventcount_s;
            dtime_A_c1    <= dtime_A_s;
            dtime_B_c1    <= dtime_B_s;
            countmode_c1  <= countmode_s;
            maskmode_c1   <= maskmode_s;
            carr_onoff_c1 <= carr_onoff_s;
            carrsel_c1    <= carrsel_s;
            logic_A_c1    <= logic_A_s;
            logic_B_c1    <= logic_B_s;
        end
    end

endmodule

// File: rtl/pwm_shadow_loader.sv
// Double-buffered PWM channel-1 loader: commits the shadow bank atomically on
// the next carrier event. Optional watchdog enabled by PWM_SHADOW_TIMEOUT_EN.
module pwm_shadow_loader
    import PKG_pwm::*;
#(
    parameter int unsigned PW     = PWMCOUNT_WIDTH,
    parameter int unsigned DW     = DTCOUNT_WIDTH,
    parameter int unsigned EW     = EVTCOUNT_WIDTH,
    parameter int unsigned TO_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SHD_AW-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              commit,
    input  logic              pwm_run,
    input  logic              sync_evt,
    output logic [PW-1:0]     period_c1,
    output logic [PW-1:0]     compare_c1,
    output logic [PW-1:0]     initcarr_c1,
    output logic [EW-1:0]     eventcount_c1,
    output logic [DW-1:0]     dtime_A_c1,
    output logic [DW-1:0]     dtime_B_c1,
    output _count_mode        countmode_c1,
    output _mask_mode         maskmode_c1,
    output _carr_onoff        carr_onoff_c1,
    output logic [2:0]        carrsel_c1,
    output logic              logic_A_c1,
    output logic              logic_B_c1,
    output logic              pending,
    output logic              loaded,
    output logic              wr_err,
    output logic              timeout
);

    _shadow_state state, state_next;
    logic         shadow_we, timeout_next;

`ifdef PWM_SHADOW_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TO_CYC + 1);
    logic [TCW-1:0] tmo_cnt;
    logic           tmo_hit;

    // Watchdog counts only while armed; leaving ARMED clears it for the next arm
    always_ff @(posedge clk) begin
        if (reset || state != ARMED) tmo_cnt <= '0;
        else                         tmo_cnt <= tmo_cnt + TCW'(1);
    end
`else
    logic to_cyc_unused;
    assign to_cyc_unused = |TO_CYC;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
`ifdef PWM_SHADOW_TIMEOUT_EN
        tmo_hit    = 1'b0;
`endif
        case (state)
            IDLE:  if (commit) state_next = pwm_run ? ARMED : LOAD;
            ARMED: begin
                if (sync_evt || !pwm_run) begin
                    state_next = LOAD;
                end
`ifdef PWM_SHADOW_TIMEOUT_EN
                else if (tmo_cnt == TCW'(TO_CYC)) begin
                    state_next = LOAD;
                    tmo_hit    = 1'b1;
                end
`endif
            end
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sticky watchdog flag, cleared by the next load reached the normal way
    always_comb begin
        timeout_next = 1'b0;
`ifdef PWM_SHADOW_TIMEOUT_EN
        timeout_next = timeout;
        if (tmo_hit)                                   timeout_next = 1'b1;
        else if (state_next == LOAD && state != LOAD)  timeout_next = 1'b0;
`endif
    end

    assign shadow_we = wr_en && (state == IDLE) && (wr_addr != SHD_ADDR_RSVD);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            loaded  <= 1'b0;
            wr_err  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            pending <= (state_next == ARMED);
            loaded  <= (state == LOAD);
            wr_err  <= wr_en && ((state != IDLE) || (wr_addr == SHD_ADDR_RSVD));
            timeout <= timeout_next;
        end
    end

    pwm_shadow_bank #(.PW(PW), .DW(DW), .EW(EW)) u_bank (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (shadow_we),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .load          (state == LOAD),
        .period_c1     (period_c1),
        .compare_c1    (compare_c1),
        .initcarr_c1   (initcarr_c1),
        .eventcount_c1 (eventcount_c1),
        .dtime_A_c1    (dtime_A_c1),
        .dtime_B_c1    (dtime_B_c1),
        .countmode_c1  (countmode_c1),
        .maskmode_c1   (maskmode_c1),
        .carr_onoff_c1 (carr_onoff_c1),
        .carrsel_c1    (carrsel_c1),
        .logic_A_c1    (logic_A_c1),
        .logic_B_c1    (logic_B_c1)
    );

endmodule

// File: tb/tb_pwm_shadow_loader.sv
// Directed self-checking bench for pwm_shadow_loader; the watchdog scenario
// is selected by PWM_SHADOW_TIMEOUT_EN.
module tb_pwm_shadow_loader;
    import PKG_pwm::*;

    localparam int unsigned PW = PWMCOUNT_WIDTH;
    localparam int unsigned DW = DTCOUNT_WIDTH;
    localparam int unsigned EW = EVTCOUNT_WIDTH;

    logic          clk = 1'b0;
    logic          reset, wr_en, commit, pwm_run, sync_evt;
    logic [2:0]    wr_addr;
    logic [15:0]   wr_data;
    logic [PW-1:0] period_c1, compare_c1, initcarr_c1;
    logic [EW-1:0] eventcount_c1;
    logic [DW-1:0] dtime_A_c1, dtime_B_c1;
    _count_mode    countmode_c1;
    _mask_mode     maskmode_c1;
    _carr_onoff    carr_onoff_c1;
    logic [2:0]    carrsel_c1;
    logic          logic_A_c1, logic_B_c1, pending, loaded, wr_err, timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_shadow_loader #(.PW(PW), .DW(DW), .EW(EW), .TO_CYC(100)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .pwm_run(pwm_run),
        .sync_evt(sync_evt), .period_c1(period_c1), .compare_c1(compare_c1),
        .initcarr_c1(initcarr_c1), .eventcount_c1(eventcount_c1),
        .dtime_A_c1(dtime_A_c1), .dtime_B_c1(dtime_B_c1),
        .countmode_c1(countmode_c1), .maskmode_c1(maskmode_c1),
        .carr_onoff_c1(carr_onoff_c1), .carrsel_c1(carrsel_c1),
        .logic_A_c1(logic_A_c1), .logic_B_c1(logic_B_c1), .pending(pending),
        .loaded(loaded), .wr_err(wr_err), .timeout(timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic pulse_sync();
        sync_evt = 1'b1;
        step();
        sync_evt = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (period_c1 !== 16'd0 || compare_c1 !== 16'd0 || initcarr_c1 !== 16'd0 ||
            eventcount_c1 !== 8'd0 || dtime_A_c1 !== 12'd0 || dtime_B_c1 !== 12'd0) begin
            bad++;
            $display("FAIL reset_values: per=%0d cmp=%0d init=%0d evt=%0d dA=%0d dB=%0d want all 0",
                     period_c1, compare_c1, initcarr_c1, eventcount_c1, dtime_A_c1, dtime_B_c1);
        end
        total++;
        if (countmode_c1 !== COUNT_UPDOWN || maskmode_c1 !== MIN_MASK || carr_onoff_c1 !== CARR_OFF ||
            carrsel_c1 !== 3'd0 || logic_A_c1 !== 1'b1 || logic_B_c1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_mode: cm=%0d mm=%0d co=%0d cs=%0d la=%0b lb=%0b want 2 1 0 0 1 1",
                     countmode_c1, maskmode_c1, carr_onoff_c1, carrsel_c1, logic_A_c1, logic_B_c1);
        end
        total++;
        if ({pending, loaded, wr_err, timeout} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {pending, loaded, wr_err, timeout});
        end
    endtask

    task automatic test_stopped();
        pwm_run = 1'b0;
        wr(3'd0, 16'd2000);
        wr(3'd1, 16'd500);
        total++;
        if (period_c1 !== 16'd0) begin
            bad++; $display("FAIL shadow_hidden: period_c1=%0d want 0", period_c1);
        end
        do_commit();
        total++;
        if (loaded !== 1'b0 || compare_c1 !== 16'd0) begin
            bad++; $display("FAIL stop_early: loaded=%0b cmp=%0d want 0 0", loaded, compare_c1);
        end
        step();
        total++;
        if (period_c1 !== 16'd2000 || compare_c1 !== 16'd500 || loaded !== 1'b1) begin
            bad++;
            $display("FAIL stop_load: per=%0d cmp=%0d loaded=%0b want 2000 500 1",
                     period_c1, compare_c1, loaded);
        end
        step();
        total++;
        if (loaded !== 1'b0 || pending !== 1'b0) begin
            bad++; $display("FAIL stop_pulse: loaded=%0b pending=%0b want 0 0", loaded, pending);
        end
    endtask

    task automatic test_running();
        int n_hi;
        pwm_run = 1'b1;
        wr(3'd1, 16'd800);
        do_commit();
        n_hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (pending === 1'b1 && compare_c1 === 16'd500 && loaded === 1'b0) n_hi++;
            if (i < 39) step();
        end
        total++;
        if (n_hi != 40) begin
            bad++; $display("FAIL run_armed: cycles armed with old compare=%0d want 40", n_hi);
        end
        pulse_sync();
        total++;
        if (pending !== 1'b0 || compare_c1 !== 16'd500) begin
            bad++; $display("FAIL run_sync: pending=%0b cmp=%0d want 0 500", pending, compare_c1);
        end
        step();
        total++;
        if (compare_c1 !== 16'd800 || loaded !== 1'b1) begin
            bad++; $display("FAIL run_load: cmp=%0d loaded=%0b want 800 1", compare_c1, loaded);
        end
    endtask

    task automatic test_run_fall();
        pwm_run = 1'b1;
        wr(3'd3, 16'h1234);
        do_commit();
        total++;
        if (pending !== 1'b1) begin
            bad++; $display("FAIL fall_arm: pending=%0b want 1", pending);
        end
        pwm_run = 1'b0;
        step();
        step();
        total++;
        if (eventcount_c1 !== 8'h34 || loaded !== 1'b1 || pending !== 1'b0) begin
            bad++;
            $display("FAIL fall_load: evt=%h loaded=%0b pending=%0b want 34 1 0",
                     eventcount_c1, loaded, pending);
        end
    endtask

    task automatic test_clamp();
        pwm_run = 1'b0;
        wr(3'd0, 16'd1000);
        wr(3'd1, 16'd1500);
        do_commit();
        step();
        total++;
        if (period_c1 !== 16'd1000 || compare_c1 !== 16'd1000) begin
            bad++; $display("FAIL clamp: per=%0d cmp=%0d want 1000 1000", period_c1, compare_c1);
        end
        wr(3'd0, 16'd0);
        do_commit();
        step();
        total++;
        if (period_c1 !== 16'd0 || compare_c1 !== 16'd0) begin
            bad++; $display("FAIL clamp_zero: per=%0d cmp=%0d want 0 0", period_c1, compare_c1);
        end
    endtask

    task automatic test_fields();
        pwm_run = 1'b0;
        wr(3'd4, 16'hFABC);
        wr(3'd5, 16'h0123);
        wr(3'd6, 16'hFEBD);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0077; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        step();
        total++;
        if (dtime_A_c1 !== 12'hABC || dtime_B_c1 !== 12'h123 || initcarr_c1 !== 16'h0077) begin
            bad++;
            $display("FAIL fields_data: dA=%h dB=%h init=%h want abc 123 0077",
                     dtime_A_c1, dtime_B_c1, initcarr_c1);
        end
        total++;
        if (countmode_c1 !== COUNT_DOWN || maskmode_c1 !== MINMAX_MASK || carr_onoff_c1 !== CARR_ON ||
            carrsel_c1 !== 3'd5 || logic_A_c1 !== 1'b0 || logic_B_c1 !== 1'b1) begin
            bad++;
            $display("FAIL fields_mode: cm=%0d mm=%0d co=%0d cs=%0d la=%0b lb=%0b want 1 3 1 5 0 1",
                     countmode_c1, maskmode_c1, carr_onoff_c1, carrsel_c1, logic_A_c1, logic_B_c1);
        end
        wr(3'd7, 16'hFFFF);
        total++;
        if (wr_err !== 1'b1) begin
            bad++; $display("FAIL rsvd_err: wr_err=%0b want 1", wr_err);
        end
        step();
        total++;
        if (wr_err !== 1'b0 || pending !== 1'b0 || loaded !== 1'b0) begin
            bad++;
            $display("FAIL rsvd_quiet: wr_err=%0b pending=%0b loaded=%0b want 0 0 0",
                     wr_err, pending, loaded);
        end
        do_commit();
        step();
        total++;
        if (initcarr_c1 !== 16'h0077 || dtime_A_c1 !== 12'hABC || carrsel_c1 !== 3'd5) begin
            bad++;
            $display("FAIL rsvd_nochange: init=%h dA=%h cs=%0d want 0077 abc 5",
                     initcarr_c1, dtime_A_c1, carrsel_c1);
        end
    endtask

    task automatic test_collisions();
        int n_ok;
        pwm_run = 1'b0;
        wr(3'd0, 16'd2000);
        wr(3'd1, 16'd600);
        pwm_run = 1'b1;
        do_commit();
        wr(3'd1, 16'd333);
        total++;
        if (wr_err !== 1'b1) begin
            bad++; $display("FAIL armed_wr_err: wr_err=%0b want 1", wr_err);
        end
        step();
        total++;
        if (wr_err !== 1'b0) begin
            bad++; $display("FAIL armed_wr_err_pulse: wr_err=%0b want 0", wr_err);
        end
        pulse_sync();
        step();
        total++;
        if (compare_c1 !== 16'd600 || loaded !== 1'b1) begin
            bad++; $display("FAIL armed_wr_drop: cmp=%0d loaded=%0b want 600 1", compare_c1, loaded);
        end
        wr(3'd1, 16'd700);
        commit = 1'b1; sync_evt = 1'b1;
        step();
        commit = 1'b0; sync_evt = 1'b0;
        n_ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (pending === 1'b1 && loaded === 1'b0 && compare_c1 === 16'd600) n_ok++;
            step();
        end
        total++;
        if (n_ok != 4) begin
            bad++; $display("FAIL commit_sync_same: armed-no-load cycles=%0d want 4", n_ok);
        end
        pulse_sync();
        step();
        total++;
        if (compare_c1 !== 16'd700 || loaded !== 1'b1) begin
            bad++; $display("FAIL commit_sync_load: cmp=%0d loaded=%0b want 700 1", compare_c1, loaded);
        end
    endtask

    task automatic test_reset_armed();
        pwm_run = 1'b1;
        wr(3'd0, 16'd3000);
        do_commit();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (period_c1 !== 16'd0 || compare_c1 !== 16'd0 || countmode_c1 !== COUNT_UPDOWN ||
            logic_A_c1 !== 1'b1 || pending !== 1'b0 || loaded !== 1'b0) begin
            bad++;
            $display("FAIL rst_armed: per=%0d cmp=%0d cm=%0d la=%0b pend=%0b ld=%0b want 0 0 2 1 0 0",
                     period_c1, compare_c1, countmode_c1, logic_A_c1, pending, loaded);
        end
        step();
        total++;
        if (pending !== 1'b0 || loaded !== 1'b0) begin
            bad++; $display("FAIL rst_idle: pending=%0b loaded=%0b want 0 0", pending, loaded);
        end
        pwm_run = 1'b0;
        do_commit();
        step();
        total++;
        if (period_c1 !== 16'd0 || loaded !== 1'b1) begin
            bad++; $display("FAIL rst_shadow: per=%0d loaded=%0b want 0 1", period_c1, loaded);
        end
    endtask

`ifdef PWM_SHADOW_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        pwm_run = 1'b0;
        wr(3'd0, 16'd100);
        wr(3'd1, 16'd50);
        pwm_run = 1'b1;
        do_commit();
        k = 0;
        while (loaded !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        total++;
        if (k != 102 || timeout !== 1'b1 || compare_c1 !== 16'd50) begin
            bad++;
            $display("FAIL timeout_load: steps=%0d timeout=%0b cmp=%0d want 102 1 50",
                     k, timeout, compare_c1);
        end
        pwm_run = 1'b0;
        do_commit();
        step();
        total++;
        if (timeout !== 1'b0 || loaded !== 1'b1) begin
            bad++; $display("FAIL timeout_clear: timeout=%0b loaded=%0b want 0 1", timeout, loaded);
        end
    endtask
`else
    task automatic test_timeout();
        pwm_run = 1'b1;
        do_commit();
        repeat (150) step();
        total++;
        if (pending !== 1'b1 || timeout !== 1'b0 || loaded !== 1'b0) begin
            bad++;
            $display("FAIL no_watchdog: pending=%0b timeout=%0b loaded=%0b want 1 0 0",
                     pending, timeout, loaded);
        end
        pulse_sync();
        step();
        total++;
        if (loaded !== 1'b1 || pending !== 1'b0) begin
            bad++; $display("FAIL no_watchdog_load: loaded=%0b pending=%0b want 1 0", loaded, pending);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish, total=%0d", total);
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'd0;
        commit = 1'b0; pwm_run = 1'b0; sync_evt = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        test_reset();
        test_stopped();
        test_running();
        test_run_fall();
        test_clamp();
        test_fields();
        test_collisions();
        test_reset_armed();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
